keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart to the display path: reads a 4x4 matrix keypad and produces debounced hex key codes 0x0..0xF.
- Downstream logic receives a one-cycle key_valid pulse per accepted press, replacing per-button handlers.
- Drives keypad columns one at a time, samples the rows, debounces over whole scans and tracks press and release.

Parameters:
- SCAN_DIV, 1000: clock cycles per column slot; minimum 2.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results needed to accept a press or a release; minimum 1.
- REPEAT_DELAY_SCANS, 64: scans from accept to first auto-repeat. Used only with the optional feature.
- REPEAT_PERIOD_SCANS, 16: scans between auto-repeats. Used only with the optional feature.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- row_sense  input  4  keypad rows, active-low (pulled up); asynchronous to clock.
- col_drive  output  4  keypad columns, active-low, exactly one bit low at a time.
- key_code  output  4  last accepted key, row*4+col.
- key_valid  output  1  one-cycle pulse when key_code is newly accepted.
- key_held  output  1  high while the accepted key is considered pressed.

Behaviour:
- Reset (async, active-high): col_drive=4'b1110, key_code=0, key_valid=0, key_held=0, FSM=IDLE, all counters 0, synchronizer flops set to 4'b1111.
- Row synchronization: row_sense passes through a 2-flop synchronizer before any use.
- Divider: counts 0..SCAN_DIV-1. Terminal count is a "tick".
- On each tick:
  - sample the synchronized rows for the current column c;
  - advance c = (c+1) mod 4;
  - col_drive = ~(1<<c) from the next cycle.
- Sampling delay: the row sample at a tick reflects a column driven for SCAN_DIV cycles, which must exceed 2 cycles for synchronizer settling.
- Scan result:
  - One full scan = columns 0,1,2,3.
  - Result = first pressed key found: lowest column first, then lowest row within that column. Otherwise NONE.
  - The result is evaluated at the tick that completes column 3.
- FSM, evaluated once per scan result:
  - IDLE: result K → DEBOUNCE with cand=K, cnt=1. If DEBOUNCE_SCANS=1, go directly to the accept action. NONE → stay.
  - DEBOUNCE:
    - result==cand → cnt++.
    - When cnt reaches DEBOUNCE_SCANS → accept: key_code=cand, key_valid=1 for one cycle, key_held=1, go to HELD.
    - Result is a different key → restart DEBOUNCE with the new cand, cnt=1.
    - NONE → IDLE.
  - HELD:
    - NONE → RELEASE, rcnt=1.
    - Any key, including a different one → stay. No rollover: a second key is ignored until full release.
  - RELEASE:
    - NONE → rcnt++. At DEBOUNCE_SCANS → key_held=0, go to IDLE.
    - Any key → back to HELD.
- Output timing: key_valid and key_held update in the cycle after the accepting or releasing tick. key_code holds its value after release.
- Latency: a clean press stable from a scan start gives key_valid at most DEBOUNCE_SCANS+1 scans plus 1 cycle later.
- Counter widths: divider $clog2(SCAN_DIV); cnt/rcnt $clog2(DEBOUNCE_SCANS+1). No wrap past the terminal value.
- Reset mid-operation: immediate return to reset values, with no key_valid emitted.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In HELD, a scan counter starts at accept.
  - After REPEAT_DELAY_SCANS scan results, key_valid pulses again with the same key_code.
  - It then repeats every REPEAT_PERIOD_SCANS scan results.
  - Scans spent in RELEASE do not advance the counter; a return to HELD resumes it.
- Not defined: exactly one key_valid per press, the repeat parameters are ignored, and no repeat counter is synthesized.

Decomposition:
- Package keypad_pkg holds:
  - KP_ROWS=4, KP_COLS=4;
  - the FSM state typedef (IDLE, DEBOUNCE, HELD, RELEASE);
  - key-code typedef logic[3:0];
  - NO_KEY flag encoding for the scan result.
- Sub-module keypad_column_driver: divider, column counter, col_drive and tick output. It is instantiated once.
- The synchronizer reuses the existing 2-flop sync cell.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, so one scan = 16 cycles):
- After reset, no keys → col_drive cycles 1110→1101→1011→0111 every 4 cycles; key_valid never asserts.
- Row1/col2 held low across 4 scans → exactly one key_valid with key_code=0x6 and key_held=1. Release → key_held=0 after 2 NONE scans; key_code stays 0x6.
- Bounce: key 0xA (row2, col2) present for 1 scan, then NONE → no key_valid, FSM returns to IDLE.
- Simultaneous keys:
  - row0 and row2 on col3 → key_code=0x3;
  - col1/row0 and col3/row0 → key_code=0x1.
- Hold 0x5, add 0x9, release 0x5 only → no new key_valid. Release all for 2 scans, then press 0x9 for 3 scans → key_valid with 0x9. Assert reset while 0x9 is held → outputs and col_drive at reset values asynchronously.
- With KEYPAD_AUTOREPEAT_EN, REPEAT_DELAY_SCANS=3, REPEAT_PERIOD_SCANS=2: hold 0xF for 10 scans → pulses at accept, accept+3, accept+5, accept+7, accept+9 scans. Without the macro → 1 pulse.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and constants for the 4x4 matrix keypad scanner.
//   KP_ROWS / KP_COLS : keypad geometry
//   key_t             : hex key code, row*4 + col
//   kp_state_t        : press/release tracking FSM states
//   scan_result_t     : outcome of one full scan (no_key flag + code)
//   NO_KEY            : scan result meaning "nothing pressed"
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    typedef logic [3:0] key_t;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } kp_state_t;

    typedef struct packed {
        logic no_key;
        key_t code;
    } scan_result_t;

    localparam scan_result_t NO_KEY = '{no_key: 1'b1, code: 4'h0};

    // Index of the lowest asserted row; lower rows win when several keys in
    // the same column are down.
    function automatic logic [1:0] lowest_row(input logic [KP_ROWS-1:0] hits);
        logic [1:0] idx;
        idx = 2'd0;
        for (int r = KP_ROWS - 1; r >= 0; r--) begin
            if (hits[r]) begin
                idx = 2'(r);
            end
        end
        return idx;
    endfunction

    function automatic key_t make_code(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// -----------------------------------------------------------------------------
// keypad_scanner_if
// Bundles the keypad matrix lines and the key event outputs.
//   row_sense : keypad rows, active-low, asynchronous to the scanner clock
//   col_drive : keypad columns, active-low, one column low at a time
//   key_code  : last accepted key (row*4 + col)
//   key_valid : one-cycle pulse when key_code is newly accepted
//   key_held  : high while the accepted key is considered pressed
// Modports:
//   master : the scanner (drives columns and key events)
//   slave  : the keypad/consumer side (drives rows, observes the rest)
// -----------------------------------------------------------------------------
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [KP_ROWS-1:0] row_sense;
    logic [KP_COLS-1:0] col_drive;
    key_t               key_code;
    logic               key_valid;
    logic               key_held;

    modport master (
        input  row_sense,
        output col_drive,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_sense,
        input  col_drive,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/keypad_scanner_column_driver.sv
// -----------------------------------------------------------------------------
// keypad_column_driver
// Slot divider and column sequencer for the keypad scan.
//   clock     : system clock
//   reset     : asynchronous, active-high
//   tick      : high in the last cycle of each column slot (sample point)
//   col       : column currently being driven (valid alongside tick)
//   col_drive : active-low column enables, starts at column 0 (4'b1110)
// Parameter SCAN_DIV: clock cycles per column slot (>= 2).
// -----------------------------------------------------------------------------
module keypad_column_driver
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic               clock,
    input  logic               reset,
    output logic               tick,
    output logic [1:0]         col,
    output logic [KP_COLS-1:0] col_drive
);

    localparam int                DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [1:0]       col_next;

    assign tick     = (div == DIV_LAST);
    assign col_next = col + 2'd1;

    // col_drive is registered so the next column is driven from the cycle
    // after the tick, giving each column a full slot to settle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div       <= '0;
            col       <= 2'd0;
            col_drive <= 4'b1110;
        end else if (tick) begin
            div       <= '0;
            col       <= col_next;
            col_drive <= ~(KP_COLS'(1) << col_next);
        end else begin
            div       <= div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad and reports debounced hex key codes.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-high
//   kp    : keypad_scanner_if.master (row_sense in; col_drive, key_code,
//           key_valid, key_held out)
// Parameters:
//   SCAN_DIV            : cycles per column slot (>= 2, > 2 for clean sampling)
//   DEBOUNCE_SCANS      : identical full-scan results to accept press/release
//   REPEAT_DELAY_SCANS  : scans from accept to first auto-repeat
//   REPEAT_PERIOD_SCANS : scans between later auto-repeats
// Build option:
//   KEYPAD_AUTOREPEAT_EN : when defined, key_valid re-pulses while a key stays
//   held; when undefined there is exactly one key_valid per press and the
//   repeat parameters are ignored.
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV            = 1000,
    parameter int DEBOUNCE_SCANS      = 4,
    parameter int REPEAT_DELAY_SCANS  = 64,
    parameter int REPEAT_PERIOD_SCANS = 16
) (
    input  logic        clock,
    input  logic        reset,
    keypad_scanner_if.master kp
);

    generate
        if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 ||
            REPEAT_DELAY_SCANS < 1 || REPEAT_PERIOD_SCANS < 1) begin : g_bad_params
            $error("keypad_scanner: parameter out of range");
        end
    endgenerate

    localparam int                CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0]  DEB_T = CNT_W'(DEBOUNCE_SCANS);

    // ------------------------------------------------------------------
    // Row synchronizer (2-flop cell). Idle rows read high, so the flops
    // come out of reset as "no key".
    // ------------------------------------------------------------------
    logic [KP_ROWS-1:0] row_meta;
    logic [KP_ROWS-1:0] row_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            // NOTE: non-blocking so row_sync takes last cycle's row_meta;
            // blocking here would collapse the two stages into one.
            row_meta <= kp.row_sense;
            row_sync <= row_meta;
        end
    end

    // ------------------------------------------------------------------
    // Column sequencing
    // ------------------------------------------------------------------
    logic               tick;
    logic [1:0]         col;
    logic [KP_COLS-1:0] col_drive;

    keypad_column_driver #(
        .SCAN_DIV (SCAN_DIV)
    ) u_column_driver (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .col       (col),
        .col_drive (col_drive)
    );

    assign kp.col_drive = col_drive;

    // ------------------------------------------------------------------
    // Scan result: the first hit in a scan is kept, so lower columns win,
    // and lowest_row() breaks ties inside a column.
    // ------------------------------------------------------------------
    logic [KP_ROWS-1:0] row_hit;
    logic               col_hit;
    key_t               col_key;
    logic               scan_done;
    logic               acc_valid;
    key_t               acc_key;
    scan_result_t       scan_result;

    assign row_hit   = ~row_sync;
    assign col_hit   = |row_hit;
    assign col_key   = make_code(lowest_row(row_hit), col);
    assign scan_done = tick && (col == 2'd3);

    // Column 3 is folded in combinationally so the result is ready at the
    // very tick that completes the scan.
    always_comb begin
        // NOTE: default assignment first so no path leaves scan_result
        // unassigned, which would infer a latch.
        scan_result = NO_KEY;
        if (acc_valid) begin
            scan_result = '{no_key: 1'b0, code: acc_key};
        end else if (col_hit) begin
            scan_result = '{no_key: 1'b0, code: col_key};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_valid <= 1'b0;
            acc_key   <= '0;
        end else if (tick) begin
            if (col == 2'd3) begin
                acc_valid <= 1'b0;
            end else if (!acc_valid && col_hit) begin
                acc_valid <= 1'b1;
                acc_key   <= col_key;
            end
        end
    end

    // ------------------------------------------------------------------
    // Press / release FSM, stepped once per scan result
    // ------------------------------------------------------------------
    kp_state_t          state;
    key_t               cand;
    logic [CNT_W-1:0]   deb_cnt;
    logic [CNT_W-1:0]   rel_cnt;
    logic [CNT_W-1:0]   deb_next;
    logic [CNT_W-1:0]   rel_next;
    key_t               key_code;
    logic               key_valid;
    logic               key_held;

    assign deb_next = deb_cnt + CNT_W'(1);
    assign rel_next = rel_cnt + CNT_W'(1);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int               RPT_MAX      = (REPEAT_DELAY_SCANS > REPEAT_PERIOD_SCANS) ?
                                                REPEAT_DELAY_SCANS : REPEAT_PERIOD_SCANS;
    localparam int               RPT_W        = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_T  = RPT_W'(REPEAT_DELAY_SCANS);
    localparam logic [RPT_W-1:0] RPT_PERIOD_T = RPT_W'(REPEAT_PERIOD_SCANS);

    // Counts scan results spent in HELD only; RELEASE scans freeze it.
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_next;
    logic             rpt_first;

    assign rpt_next = rpt_cnt + RPT_W'(1);
`else
    // Single key_valid per press: no repeat state exists in this build.
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= '0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
        end else begin
            key_valid <= 1'b0;
            if (scan_done) begin
                unique case (state)
                    IDLE: begin
                        if (!scan_result.no_key) begin
                            cand <= scan_result.code;
                            if (DEBOUNCE_SCANS == 1) begin
                                key_code  <= scan_result.code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb_cnt   <= '0;
                                state     <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rpt_cnt   <= '0;
                                rpt_first <= 1'b1;
`endif
                            end else begin
                                deb_cnt <= CNT_W'(1);
                                state   <= DEBOUNCE;
                            end
                        end
                    end

                    DEBOUNCE: begin
                        if (scan_result.no_key) begin
                            deb_cnt <= '0;
                            state   <= IDLE;
                        end else if (scan_result.code != cand) begin
                            cand    <= scan_result.code;
                            deb_cnt <= CNT_W'(1);
                        end else if (deb_next == DEB_T) begin
                            key_code  <= cand;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            deb_cnt   <= '0;
                            state     <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rpt_cnt   <= '0;
                            rpt_first <= 1'b1;
`endif
                        end else begin
                            deb_cnt <= deb_next;
                        end
                    end

                    HELD: begin
                        // Any key keeps the press alive: no rollover to a
                        // second key until everything is released.
                        if (scan_result.no_key) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                key_held <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                rel_cnt <= CNT_W'(1);
                                state   <= RELEASE;
                            end
                        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                            if (rpt_next == (rpt_first ? RPT_DELAY_T : RPT_PERIOD_T)) begin
                                key_valid <= 1'b1;
                                rpt_cnt   <= '0;
                                rpt_first <= 1'b0;
                            end else begin
                                rpt_cnt   <= rpt_next;
                            end
`endif
                        end
                    end

                    RELEASE: begin
                        if (scan_result.no_key) begin
                            if (rel_next == DEB_T) begin
                                key_held <= 1'b0;
                                rel_cnt  <= '0;
                                state    <= IDLE;
                            end else begin
                                rel_cnt <= rel_next;
                            end
                        end else begin
                            rel_cnt <= '0;
                            state   <= HELD;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign kp.key_code  = key_code;
    assign kp.key_valid = key_valid;
    assign kp.key_held  = key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2
// (one scan = 16 cycles), REPEAT_DELAY_SCANS=3, REPEAT_PERIOD_SCANS=2.
// A keypad model turns a 16-bit "pressed" mask into row_sense from col_drive.
// Expected key codes are queued when a press is driven and compared when
// key_valid pulses.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic        clock;
    logic        reset;
    logic [15:0] mask;

    keypad_scanner_if bus();

    keypad_scanner #(
        .SCAN_DIV            (4),
        .DEBOUNCE_SCANS      (2),
        .REPEAT_DELAY_SCANS  (3),
        .REPEAT_PERIOD_SCANS (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .kp    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Physical keypad: a pressed key shorts its row to its column.
    always_comb begin
        bus.row_sense = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (mask[r*4 + c] && !bus.col_drive[c]) begin
                    bus.row_sense[r] = 1'b0;
                end
            end
        end
    end

    int   n_cmp;
    int   n_bad;
    key_t exp_q[$];
    key_t mon_code;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Scoreboard side: every key_valid pulse must match a queued press.
    always @(negedge clock) begin
        if (!reset && bus.key_valid === 1'b1) begin
            check("valid_was_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_code = exp_q.pop_front();
                check("valid_key_code", 32'(bus.key_code), 32'(mon_code));
                check("held_at_valid", 32'(bus.key_held), 32'd1);
            end
        end
    end

    // Return #1 after the edge where column 0 is driven again (scan start).
    task automatic next_scan();
        logic [3:0] prev;
        logic       seen;
        prev = bus.col_drive;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clock);
            #1;
            if (bus.col_drive == 4'b1110 && prev != 4'b1110) seen = 1'b1;
            prev = bus.col_drive;
        end
        check("scan_boundary_seen", 32'(seen), 32'd1);
    endtask

    task automatic scans(input int n);
        for (int i = 0; i < n; i++) next_scan();
    endtask

    typedef struct {
        logic [15:0] mask;
        int          hold;
        logic        accept;
        key_t        code;
    } vec_t;

    vec_t       vecs[6];
    key_t       last_code;
    logic [3:0] rot[4];

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        mask      = 16'h0000;
        reset     = 1'b1;
        last_code = 4'h0;

        vecs[0] = '{mask: 16'h0040, hold: 4, accept: 1'b1, code: 4'h6}; // row1/col2
        vecs[1] = '{mask: 16'h0400, hold: 1, accept: 1'b0, code: 4'hA}; // bounce
        vecs[2] = '{mask: 16'h0808, hold: 3, accept: 1'b1, code: 4'h3}; // col3 rows 0,2
        vecs[3] = '{mask: 16'h000A, hold: 3, accept: 1'b1, code: 4'h1}; // row0 cols 1,3
        vecs[4] = '{mask: 16'h0001, hold: 2, accept: 1'b1, code: 4'h0}; // exactly 2 scans
        vecs[5] = '{mask: 16'h8000, hold: 2, accept: 1'b1, code: 4'hF};
        rot[0] = 4'b1110; rot[1] = 4'b1101; rot[2] = 4'b1011; rot[3] = 4'b0111;

        // Reset values
        #2;
        check("rst_col_drive", 32'(bus.col_drive), 32'h0000000E);
        check("rst_key_code",  32'(bus.key_code),  32'd0);
        check("rst_key_valid", 32'(bus.key_valid), 32'd0);
        check("rst_key_held",  32'(bus.key_held),  32'd0);
        #20 reset = 1'b0;

        // Column rotation with no keys
        next_scan();
        check("rot_col0", 32'(bus.col_drive), 32'(rot[0]));
        for (int k = 1; k < 4; k++) begin
            repeat (4) @(posedge clock);
            #1;
            check("rot_col", 32'(bus.col_drive), 32'(rot[k]));
        end
        scans(1);

        // Table-driven presses: hold, then release with 2-scan boundary
        for (int i = 0; i < 6; i++) begin
            next_scan();
            mask = vecs[i].mask;
            if (vecs[i].accept) begin
                exp_q.push_back(vecs[i].code);
                last_code = vecs[i].code;
            end
            scans(vecs[i].hold);
            check("held_after_press", 32'(bus.key_held), 32'(vecs[i].accept));
            mask = 16'h0000;
            scans(1);
            check("held_after_1_none", 32'(bus.key_held), 32'(vecs[i].accept));
            scans(1);
            check("held_after_2_none", 32'(bus.key_held), 32'd0);
            scans(1);
            check("code_after_release", 32'(bus.key_code), 32'(last_code));
        end

        // No rollover: hold 5, add 9, drop 5 -> no new pulse
        mask = 16'h0020;
        exp_q.push_back(4'h5);
        scans(2);
        check("held_5", 32'(bus.key_held), 32'd1);
        mask = 16'h0220;
        scans(1);
        mask = 16'h0200;
        scans(1);
        check("still_held_5", 32'(bus.key_held), 32'd1);
        check("code_still_5", 32'(bus.key_code), 32'h5);
        mask = 16'h0000;
        scans(2);
        check("released_5", 32'(bus.key_held), 32'd0);
        mask = 16'h0200;
        exp_q.push_back(4'h9);
        scans(3);
        check("held_9", 32'(bus.key_held), 32'd1);
        check("code_9", 32'(bus.key_code), 32'h9);

        // Asynchronous reset mid-press
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrst_col_drive", 32'(bus.col_drive), 32'h0000000E);
        check("midrst_key_code",  32'(bus.key_code),  32'd0);
        check("midrst_key_valid", 32'(bus.key_valid), 32'd0);
        check("midrst_key_held",  32'(bus.key_held),  32'd0);
        mask = 16'h0000;
        repeat (3) @(posedge clock);
        #3 reset = 1'b0;

        // Long hold of 0xF: accept at scan 2; repeats at scans 5,7,9,11 when enabled
        next_scan();
        mask = 16'h8000;
        exp_q.push_back(4'hF);
`ifdef KEYPAD_AUTOREPEAT_EN
        for (int i = 0; i < 4; i++) exp_q.push_back(4'hF);
`endif
        scans(12);
        check("held_F", 32'(bus.key_held), 32'd1);
        mask = 16'h0000;
        scans(3);
        check("released_F", 32'(bus.key_held), 32'd0);
        check("code_F_kept", 32'(bus.key_code), 32'hF);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
